// File: rtl/knap_enum_search.sv
// knap_enum_search: sweeps every selection vector through a combinational knapsack
// checker and queues feasible vectors in a solution FIFO.  Rev 1.0
`default_nettype none

module knap_enum_search #(
  parameter int N_ITEMS    = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic [N_ITEMS-1:0] cand_o,
  input  logic               chk_valid_i,
  output logic [N_ITEMS-1:0] sol_data_o,
  output logic               sol_valid_o,
  input  logic               sol_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_ITEMS:0]   sol_count_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]        DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [N_ITEMS-1:0] CAND_LAST = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [N_ITEMS-1:0] cand_q, cand_d;
  logic [N_ITEMS:0]   count_q, count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        occ_q, occ_d;
  logic [N_ITEMS-1:0] mem_q [FIFO_DEPTH];

  logic w_run;
  logic w_pop;
  logic w_full;
  logic w_can_push;
  logic w_push;
  logic w_retire;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_run      = (state_q == S_RUN);
    w_pop      = (occ_q != '0) && sol_ready_i;
    w_full     = (occ_q == DEPTH_C);
    w_can_push = !w_full || w_pop;
    w_push     = w_run && chk_valid_i && w_can_push;
    w_retire   = w_run && (!chk_valid_i || w_can_push);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          cand_d  = '0;
          count_d = '0;
        end
      end
      S_RUN: begin
        if (w_push) begin
          count_d = count_q + (N_ITEMS+1)'(1);
        end
        if (w_retire) begin
          if (cand_q == CAND_LAST) begin
            state_d = S_DONE;
          end else begin
            cand_d = cand_q + N_ITEMS'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= cand_q;
    end
  end

  assign cand_o      = cand_q;
  assign sol_valid_o = (occ_q != '0);
  assign sol_data_o  = sol_valid_o ? mem_q[rd_ptr_q] : '0;
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign sol_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_knap_enum_search.sv
// tb_knap_enum_search: vector table, random sweeps and hand sequences against a queue model.
`default_nettype none

module tb_knap_enum_search;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int NC = 1 << N;
  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  logic         clk;
  logic         rst;
  logic         start_i;
  logic [N-1:0] cand_o;
  logic         chk_valid_i;
  logic [N-1:0] sol_data_o;
  logic         sol_valid_o;
  logic         sol_ready_i;
  logic         busy_o;
  logic         done_o;
  logic [N:0]   sol_count_o;

  logic [NC-1:0] mask;

  knap_enum_search #(.N_ITEMS(N), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .cand_o      (cand_o),
    .chk_valid_i (chk_valid_i),
    .sol_data_o  (sol_data_o),
    .sol_valid_o (sol_valid_o),
    .sol_ready_i (sol_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sol_count_o (sol_count_o)
  );

  assign chk_valid_i = mask[cand_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_state;
  int m_cand;
  int m_count;
  int q[$];
  int got[$];

  typedef struct {
    logic [NC-1:0] mask;
    int            ready_pct;
    int            exp_count;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE;
    m_cand  = 0;
    m_count = 0;
    q.delete();
  endtask

  task automatic model_step(input logic st, input logic rdy);
    bit pop, cv, canp, push, retire;
    pop = (q.size() > 0) && rdy;
    if (m_state == ST_RUN) begin
      cv     = mask[m_cand];
      canp   = (q.size() < D) || pop;
      push   = cv && canp;
      retire = !cv || canp;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(m_cand);
        m_count++;
      end
      if (retire) begin
        if (m_cand == NC - 1) m_state = ST_DONE;
        else m_cand++;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (st) begin
        m_state = ST_RUN;
        m_cand  = 0;
        m_count = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("cand", 32'(cand_o), 32'(m_cand));
    check("busy", 32'(busy_o), 32'(m_state == ST_RUN));
    check("done", 32'(done_o), 32'(m_state == ST_DONE));
    check("sol_valid", 32'(sol_valid_o), 32'(q.size() > 0));
    check("sol_count", 32'(sol_count_o), 32'(m_count));
    if (q.size() > 0) check("sol_data", 32'(sol_data_o), 32'(q[0]));
  endtask

  // Inputs change at posedge+1; the model advances on the edge and outputs are compared 1 ns later.
  task automatic tick(input logic st, input logic rdy);
    start_i     = st;
    sol_ready_i = rdy;
    if (sol_valid_o && rdy) got.push_back(int'(sol_data_o));
    @(posedge clk);
    model_step(st, rdy);
    #1;
    compare_all();
    start_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cand"}, 32'(cand_o), 32'd0);
    check({tag, "_valid"}, 32'(sol_valid_o), 32'd0);
    check({tag, "_data"}, 32'(sol_data_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_count"}, 32'(sol_count_o), 32'd0);
  endtask

  initial begin
    int n;
    rst         = 1'b0;
    start_i     = 1'b0;
    sol_ready_i = 1'b0;
    mask        = '0;

    // Asynchronous reset between edges, then held across edges with start low.
    #2 rst = 1'b1;
    #1 check_zero_outputs("reset_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_zero_outputs("reset_hold");
    rst = 1'b0;
    model_reset();
    tick(1'b0, 1'b0);
    check_zero_outputs("idle_no_start");

    // Basic sweep: feasible set {5, 9}.
    mask = NC'(16'h0220);
    got.delete();
    tick(1'b1, 1'b1);
    check("basic_busy_rise", 32'(busy_o), 32'd1);
    n = 0;
    for (int i = 0; i < 100 && !done_o; i++) begin
      tick(1'b0, 1'b1);
      n++;
    end
    check("basic_sweep_len", 32'(n), 32'd16);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check("basic_count", 32'(sol_count_o), 32'd2);
    check("basic_num_sols", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("basic_sol0", 32'(got[0]), 32'd5);
      check("basic_sol1", 32'(got[1]), 32'd9);
    end

    // Back-pressure: everything feasible, consumer stalled.
    mask = '1;
    got.delete();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    check("bp_stall_cand", 32'(cand_o), 32'd4);
    check("bp_stall_busy", 32'(busy_o), 32'd1);
    check("bp_stall_count", 32'(sol_count_o), 32'd4);
    check("bp_stall_head", 32'(sol_data_o), 32'd0);
    // Full FIFO with a single-cycle pop: push and pop together, occupancy stays full.
    tick(1'b0, 1'b1);
    check("fullpop_cand", 32'(cand_o), 32'd5);
    check("fullpop_head", 32'(sol_data_o), 32'd1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    check("fullpop_still_full", 32'(cand_o), 32'd5);
    n = 0;
    for (int i = 0; i < 200 && !done_o; i++) begin
      tick(1'b0, 1'b1);
      n++;
    end
    check("bp_done", 32'(done_o), 32'd1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
    check("bp_count", 32'(sol_count_o), 32'd16);
    check("bp_num_sols", 32'(got.size()), 32'd16);
    for (int i = 0; i < got.size() && i < 16; i++) check("bp_order", 32'(got[i]), 32'(i));

    // Reset mid-sweep at cand 7 with 5 and 6 queued.
    mask = NC'(16'h0060);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 20 && cand_o != 4'd7; i++) tick(1'b0, 1'b0);
    check("mid_cand", 32'(cand_o), 32'd7);
    check("mid_queued", 32'(sol_count_o), 32'd2);
    check("mid_valid", 32'(sol_valid_o), 32'd1);
    #3 rst = 1'b1;
    #1 check_zero_outputs("mid_reset");
    @(posedge clk); #1;
    check_zero_outputs("mid_reset_hold");
    rst = 1'b0;
    model_reset();
    tick(1'b1, 1'b0);
    check("restart_cand", 32'(cand_o), 32'd0);
    check("restart_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 100 && !done_o; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);

    // Table of fixed and random feasibility sets under random consumer readiness.
    vecs[0] = '{NC'(16'h0000), 100, 0};
    vecs[1] = '{NC'(16'hFFFF), 100, 16};
    vecs[2] = '{NC'(16'h8001), 50, 2};
    vecs[3] = '{NC'(16'hAAAA), 30, 8};
    vecs[4] = '{NC'(16'h1248), 70, 4};
    for (int v = 5; v < 9; v++) begin
      vecs[v].mask      = NC'($urandom);
      vecs[v].ready_pct = int'($urandom_range(10, 100));
      vecs[v].exp_count = $countones(vecs[v].mask);
    end
    for (int v = 0; v < 9; v++) begin
      mask = vecs[v].mask;
      got.delete();
      tick(1'b1, 1'b0);
      for (int i = 0; i < 600 && !done_o; i++)
        tick(1'b0, logic'($urandom_range(1, 100) <= vecs[v].ready_pct));
      check("vec_done", 32'(done_o), 32'd1);
      for (int i = 0; i < 20 && sol_valid_o; i++) tick(1'b0, 1'b1);
      check("vec_drained", 32'(sol_valid_o), 32'd0);
      check("vec_count", 32'(sol_count_o), 32'(vecs[v].exp_count));
      check("vec_num_sols", 32'(got.size()), 32'(vecs[v].exp_count));
      for (int i = 0; i < got.size(); i++) begin
        check("vec_sol_feasible", 32'(vecs[v].mask[got[i]]), 32'd1);
        if (i > 0) check("vec_sol_ascending", 32'(got[i] > got[i-1]), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/knap_enum_search.md
# knap_enum_search

Exhaustive candidate enumerator that sits directly upstream of the combinational knapsack feasibility checker. It drives every N_ITEMS-bit selection vector onto the checker, one per clock, and samples the checker's `valid` result in the same cycle. Feasible vectors are captured into a small solution FIFO, which a downstream consumer drains through a ready/valid handshake. A full FIFO back-pressures the sweep.

## Interface
- `N_ITEMS`, default 23: width of the selection vector, bit i = item i; bit 0 = item A.
- `FIFO_DEPTH`, default 4: solution FIFO entries; power of two, ≥ 2.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled in IDLE or DONE, ignored in RUN.
- `cand`  out  N_ITEMS  candidate vector driven to the checker item inputs.
- `chk_valid`  in  1  checker result for the current `cand`, combinational from `cand`.
- `sol_data`  out  N_ITEMS  head-of-FIFO feasible vector.
- `sol_valid`  out  1  FIFO non-empty.
- `sol_ready`  in  1  consumer accepts `sol_data`.
- `busy`  out  1  state == RUN.
- `done`  out  1  state == DONE.
- `sol_count`  out  N_ITEMS+1  feasible vectors pushed in the current sweep.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last candidate retired--> DONE.
  - DONE --start--> RUN.
- Entering RUN: `cand` ← 0 and `sol_count` ← 0. The FIFO is not flushed; pending solutions still drain.
- Each RUN cycle evaluates the pair (`cand`, `chk_valid`):
  - `pop` = `sol_valid` && `sol_ready`.
  - `can_push` = !full || `pop`. Push is allowed into a full FIFO only when a pop happens in the same cycle.
  - If `chk_valid` && `can_push`: push `cand`, increment `sol_count`, retire `cand`.
  - If `chk_valid` && !`can_push`: stall. `cand` holds and nothing is pushed; the same vector is re-evaluated next cycle.
  - If !`chk_valid`: retire `cand`.
  - Retire means: if `cand` == all-ones, go to DONE and hold `cand`; otherwise `cand` ← `cand` + 1.
- `sol_count` never wraps. Its maximum is 2^N_ITEMS, which fits in N_ITEMS+1 bits.
- The FIFO pops in any state whenever `pop` is true. It is first-in first-out, so solutions emerge in ascending `cand` order.
- `chk_valid` is ignored outside RUN.
- Reset values: state IDLE; `cand`=0, `sol_valid`=0, `sol_data`=0, `busy`=0, `done`=0, `sol_count`=0. The FIFO is emptied: read/write pointers and occupancy are 0.
- Reset mid-sweep aborts immediately. All FIFO contents are lost.

## Timing
- `start` sampled high at edge k: `busy`=1 and `cand`=0 after edge k, so the first evaluation happens in cycle k+1.
- With no stalls, the sweep occupies exactly 2^N_ITEMS RUN cycles. `done` rises on the edge that retires all-ones.
- Push at edge t: `sol_valid`=1 after edge t if the FIFO was empty. `sol_data` is registered at the FIFO head, not combinational from `cand`.
- `sol_valid`/`sol_data` hold stable while `sol_ready`=0 (standard valid/ready: no retraction).
- `cand` changes only on clock edges, so the checker path is a single-cycle combinational path: `cand` → checker → `chk_valid` → FIFO/counter registers.
- Push and pop in the same cycle leave occupancy unchanged.

## Test plan
- Reset: assert `rst` asynchronously between edges → all outputs 0 immediately, and they stay 0 with `start`=0.
- Basic sweep: N_ITEMS=4, model `chk_valid` = (`cand`==5 || `cand`==9), `sol_ready`=1, pulse `start` → `sol_data` 5 then 9; `done`=1 exactly 16 cycles after `busy` rose; `sol_count`=2.
- Back-pressure: N_ITEMS=4, DEPTH=4, `chk_valid`=1 always, `sol_ready`=0 → pushes 0,1,2,3 and `cand` stalls at 4 with `busy`=1. Raise `sol_ready` → drain order 0..15, `sol_count`=16, `done` only after 15 is pushed.
- Full with simultaneous pop: FIFO full, `chk_valid`=1, `sol_ready`=1 for one cycle → head popped and `cand` pushed in the same cycle; occupancy stays 4; `cand` advances.
- Reset mid-sweep at `cand`=7 with 2 entries queued → IDLE, `sol_valid`=0, `sol_count`=0. A following `start` restarts the sweep from `cand`=0.
- Full-width: N_ITEMS=23, connected to the 23-item checker, `sol_ready`=1 → `sol_count` equals the golden-model feasible count, every `sol_data` re-checks as feasible, and `done` asserts after 2^23 cycles.
